// File: rtl/md5_msg_gen.sv
// MD5 advent-coin message-block generator: key || decimal counter, padded.
// Optional: MD5_MSG_GEN_NUMBER_TAG_EN builds a binary counter that drives o_number.
module md5_msg_gen #(
    parameter int MAX_KEY_BYTES = 16,
    parameter int NUM_DIGITS    = 7,
    parameter int WORD_BITS     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      key_valid,
    input  logic [7:0]                key_byte,
    input  logic                      key_last,
    input  logic                      halt,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [16*WORD_BITS-1:0]   o_block,
    output logic [31:0]               o_number,
    output logic                      o_exhausted,
    output logic                      o_key_overflow
);

    localparam int KLW = $clog2(MAX_KEY_BYTES + 1);
    localparam int NDW = $clog2(NUM_DIGITS + 1);
    localparam int DW  = NUM_DIGITS * 4;

    if (MAX_KEY_BYTES + NUM_DIGITS > 55) begin : g_bad_len
        $error("md5_msg_gen: MAX_KEY_BYTES + NUM_DIGITS must be <= 55");
    end
    if (WORD_BITS != 32) begin : g_bad_word
        $error("md5_msg_gen: WORD_BITS must be 32");
    end

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;

    state_t                          state_q;
    logic [MAX_KEY_BYTES*8-1:0]      key_q, key_n;
    logic [KLW-1:0]                  klen_q, klen_n;
    logic [NUM_DIGITS-1:0][3:0]      dig_q, dig_n, dig_sel;
    logic [NDW-1:0]                  nd_q, nd_n, nd_sel;
    logic                            ovf_n, carry, wrap;
    logic                            xfer, load_fire, ld_fire, adv;
    logic [16*WORD_BITS-1:0]         blk_n;

    assign xfer      = o_valid && o_ready;
    assign load_fire = key_valid && key_last;
    assign ld_fire   = state_q == S_LOAD && load_fire && !halt;
    assign adv       = state_q == S_RUN && xfer && !halt && !wrap;

    // Key capture; bytes past the buffer only raise the overflow flag
    always_comb begin
        key_n  = key_q;
        klen_n = klen_q;
        ovf_n  = o_key_overflow;
        if (state_q == S_LOAD && key_valid) begin
            if (klen_q == KLW'(MAX_KEY_BYTES)) begin
                ovf_n = 1'b1;
            end else begin
                for (int i = 0; i < MAX_KEY_BYTES; i++)
                    if (klen_q == KLW'(i)) key_n[8*i +: 8] = key_byte;
                klen_n = klen_q + KLW'(1);
            end
        end
    end

    always_comb begin
        dig_n = dig_q;
        nd_n  = nd_q;
        carry = 1'b1;
        wrap  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (NDW'(i) < nd_q && carry) begin
                if (dig_n[i] == 4'd9) begin
                    dig_n[i] = 4'd0;
                end else begin
                    dig_n[i] = dig_n[i] + 4'd1;
                    carry    = 1'b0;
                end
            end
        end
        if (carry) begin
            if (nd_q == NDW'(NUM_DIGITS)) begin
                wrap = 1'b1;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    if (NDW'(i) == nd_q) dig_n[i] = 4'd1;
                nd_n = nd_q + NDW'(1);
            end
        end
    end

    // The block register always loads the value about to be presented
    assign dig_sel = (state_q == S_LOAD) ? dig_q : dig_n;
    assign nd_sel  = (state_q == S_LOAD) ? nd_q  : nd_n;

    always_comb begin
        int kl;
        int nd;
        int off;
        blk_n = '0;
        kl    = int'(klen_n);
        nd    = int'(nd_sel);
        off   = 0;
        for (int i = 0; i < MAX_KEY_BYTES; i++)
            if (i < kl) blk_n[8*i +: 8] = key_n[8*i +: 8];
        for (int b = 0; b < 56; b++) begin
            off = b - kl;
            if (off >= 0 && off < nd) begin
                for (int k = 0; k < NUM_DIGITS; k++)
                    if (k == nd - 1 - off) blk_n[8*b +: 8] = {4'h3, dig_sel[k]};
            end else if (off == nd) begin
                blk_n[8*b +: 8] = 8'h80;
            end
        end
        blk_n[32*14 +: 32] = 32'(8 * (kl + nd));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_LOAD;
            key_q          <= '0;
            klen_q         <= '0;
            dig_q          <= DW'(1);
            nd_q           <= NDW'(1);
            o_valid        <= 1'b0;
            o_block        <= '0;
            o_exhausted    <= 1'b0;
            o_key_overflow <= 1'b0;
        end else begin
            o_key_overflow <= ovf_n;
            case (state_q)
                S_LOAD: begin
                    key_q  <= key_n;
                    klen_q <= klen_n;
                    if (halt) begin
                        state_q <= S_DONE;
                    end else if (ld_fire) begin
                        state_q <= S_RUN;
                        o_valid <= 1'b1;
                        o_block <= blk_n;
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        state_q <= S_DONE;
                        o_valid <= 1'b0;
                    end else if (xfer && wrap) begin
                        state_q     <= S_DONE;
                        o_valid     <= 1'b0;
                        o_exhausted <= 1'b1;
                    end else if (adv) begin
                        dig_q   <= dig_n;
                        nd_q    <= nd_n;
                        o_block <= blk_n;
                    end
                end
                default: o_valid <= 1'b0;
            endcase
        end
    end

`ifdef MD5_MSG_GEN_NUMBER_TAG_EN
    logic [31:0] bin_q, num_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q <= 32'd1;
            num_q <= '0;
        end else if (ld_fire) begin
            num_q <= bin_q;
        end else if (adv) begin
            bin_q <= bin_q + 32'd1;
            num_q <= bin_q + 32'd1;
        end
    end

    assign o_number = num_q;
`else
    assign o_number = '0;
`endif

endmodule

// File: tb/tb_md5_msg_gen.sv
// Scoreboard bench for md5_msg_gen: default instance plus a small
// instance (4-byte key, 2 digits) for overflow and exhaustion.
module tb_md5_msg_gen;

    typedef struct {
        logic [511:0] blk;
        logic [31:0]  num;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         a_reset, a_kv, a_kl, a_halt, a_ready;
    logic [7:0]   a_kb;
    logic         a_valid, a_exh, a_ovf;
    logic [511:0] a_block;
    logic [31:0]  a_number;

    logic         b_reset, b_kv, b_kl, b_halt, b_ready;
    logic [7:0]   b_kb;
    logic         b_valid, b_exh, b_ovf;
    logic [511:0] b_block;
    logic [31:0]  b_number;

    md5_msg_gen u_a (
        .clk(clk), .reset(a_reset), .key_valid(a_kv), .key_byte(a_kb),
        .key_last(a_kl), .halt(a_halt), .o_valid(a_valid), .o_ready(a_ready),
        .o_block(a_block), .o_number(a_number), .o_exhausted(a_exh),
        .o_key_overflow(a_ovf)
    );

    md5_msg_gen #(.MAX_KEY_BYTES(4), .NUM_DIGITS(2)) u_b (
        .clk(clk), .reset(b_reset), .key_valid(b_kv), .key_byte(b_kb),
        .key_last(b_kl), .halt(b_halt), .o_valid(b_valid), .o_ready(b_ready),
        .o_block(b_block), .o_number(b_number), .o_exhausted(b_exh),
        .o_key_overflow(b_ovf)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] expb(input string key, input int maxk,
                                          input int n);
        logic [7:0]   m [64];
        string        ds;
        int           kl;
        int           dl;
        logic [511:0] r;
        for (int i = 0; i < 64; i++) m[i] = 8'h00;
        kl = (key.len() > maxk) ? maxk : key.len();
        ds = $sformatf("%0d", n);
        dl = ds.len();
        for (int i = 0; i < kl; i++) m[i] = key[i];
        for (int j = 0; j < dl; j++) m[kl+j] = ds[j];
        m[kl+dl] = 8'h80;
        r = '0;
        for (int w = 0; w < 14; w++)
            r[32*w +: 32] = {m[4*w+3], m[4*w+2], m[4*w+1], m[4*w]};
        r[32*14 +: 32] = 32'(8 * (kl + dl));
        return r;
    endfunction

    function automatic logic [31:0] expn(input int n);
`ifdef MD5_MSG_GEN_NUMBER_TAG_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic push(input int which, input int maxk, input int lo,
                        input int hi);
        exp_t e;
        for (int n = lo; n <= hi; n++) begin
            e.blk = expb("abcdef", maxk, n);
            e.num = expn(n);
            if (which == 0) qa.push_back(e);
            else qb.push_back(e);
        end
    endtask

    task automatic load(input int which, input string k);
        for (int i = 0; i < k.len(); i++) begin
            @(posedge clk) #1;
            if (which == 0) begin
                a_kv = 1'b1; a_kb = k[i]; a_kl = (i == k.len() - 1);
            end else begin
                b_kv = 1'b1; b_kb = k[i]; b_kl = (i == k.len() - 1);
            end
        end
        @(posedge clk) #1;
        a_kv = 1'b0; a_kl = 1'b0;
        b_kv = 1'b0; b_kl = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!a_reset && a_valid && a_ready) begin
            if (qa.size() == 0) begin
                chk("a_extra_xfer", a_block, '0);
            end else begin
                e = qa.pop_front();
                chk("a_sb_block", a_block, e.blk);
                chk("a_sb_number", a_number, e.num);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!b_reset && b_valid && b_ready) begin
            if (qb.size() == 0) begin
                chk("b_extra_xfer", b_block, '0);
            end else begin
                e = qb.pop_front();
                chk("b_sb_block", b_block, e.blk);
                chk("b_sb_number", b_number, e.num);
            end
        end
    end

    initial begin
        logic [511:0] e3;
        logic [511:0] e5;
        bit           found;
        a_reset = 1'b1; a_kv = 1'b0; a_kl = 1'b0; a_kb = '0;
        a_halt  = 1'b0; a_ready = 1'b1;
        b_reset = 1'b1; b_kv = 1'b0; b_kl = 1'b0; b_kb = '0;
        b_halt  = 1'b0; b_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 512'(a_valid), 512'(0));
        chk("rst_block", a_block, '0);
        chk("rst_number", 512'(a_number), 512'(0));
        chk("rst_exh", 512'(a_exh), 512'(0));
        chk("rst_ovf", 512'(a_ovf), 512'(0));

        // First block, digit rollover, back-to-back delivery
        push(0, 16, 1, 10);
        load(0, "abcdef");
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("a_seq_%0d", k), a_block, expb("abcdef", 16, k));
            chk("a_seq_valid", 512'(a_valid), 512'(1));
            if (k == 1) begin
                chk("first_m0", 512'(a_block[31:0]), 512'(32'h64636261));
                chk("first_m1", 512'(a_block[63:32]), 512'(32'h80316665));
                chk("first_m2_13", 512'(a_block[447:64]), 512'(0));
                chk("first_m14", 512'(a_block[479:448]), 512'(32'h38));
                chk("first_m15", 512'(a_block[511:480]), 512'(0));
            end
            if (k == 10) begin
                chk("roll_m1", 512'(a_block[63:32]), 512'(32'h30316665));
                chk("roll_m2", 512'(a_block[95:64]), 512'(32'h80));
                chk("roll_m14", 512'(a_block[479:448]), 512'(32'h40));
            end
        end
        @(posedge clk) #1;
        a_ready = 1'b0;
        chk("a_q_drained", 512'(qa.size()), 512'(0));

        // Mid-run reset drops the presented block
        a_reset = 1'b1;
        @(posedge clk) #1;
        a_reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 512'(a_valid), 512'(0));
        chk("mid_rst_block", a_block, '0);

        // Reload, backpressure on 3, halt on 5
        a_ready = 1'b1;
        push(0, 16, 1, 5);
        load(0, "abcdef");
        @(negedge clk);
        @(negedge clk);
        @(posedge clk) #1;
        a_ready = 1'b0;
        e3 = expb("abcdef", 16, 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_block", a_block, e3);
            chk("bp_number", 512'(a_number), 512'(expn(3)));
            chk("bp_valid", 512'(a_valid), 512'(1));
        end
        @(posedge clk) #1;
        a_ready = 1'b1;
        e5 = expb("abcdef", 16, 5);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (a_valid && a_block == e5) found = 1'b1;
        end
        chk("reach_5", 512'(found), 512'(1));
        a_halt = 1'b1;
        @(posedge clk) #1;
        a_halt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("halt_valid", 512'(a_valid), 512'(0));
        end
        chk("halt_q_empty", 512'(qa.size()), 512'(0));
        chk("a_no_exh", 512'(a_exh), 512'(0));

        // Small instance: key overflow and counter exhaustion at 99
        push(1, 4, 1, 99);
        load(1, "abcdef");
        @(negedge clk);
        chk("ovf_flag", 512'(b_ovf), 512'(1));
        chk("ovf_m1", 512'(b_block[63:32]), 512'(32'h00008031));
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (b_exh) found = 1'b1;
        end
        chk("exh_flag", 512'(found), 512'(1));
        chk("exh_q_empty", 512'(qb.size()), 512'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("exh_valid", 512'(b_valid), 512'(0));
            chk("exh_sticky", 512'(b_exh), 512'(1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/md5_msg_gen.md
# md5_msg_gen

Message-block generator for the MD5 advent-coin search. It sits upstream of the MD5 step pipeline and supplies its message words. It captures a secret key as a byte stream, then walks a decimal counter starting at 1. For each counter value it emits one fully padded 512-bit MD5 block containing key‖decimal-digits, one block per accepted transfer.

## Interface
- `MAX_KEY_BYTES`, default 16: key buffer depth in bytes.
- `NUM_DIGITS`, default 7: maximum number of decimal digits. `MAX_KEY_BYTES + NUM_DIGITS` must be ≤ 55; elaboration-time assertion.
- `WORD_BITS`, default 32: MD5 word width. Only 32 is legal.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `key_valid` input 1: key byte strobe.
- `key_byte` input 8: key character (ASCII).
- `key_last` input 1: marks the final key byte; qualified by `key_valid`.
- `halt` input 1: stop generation (e.g. solution found).
- `o_valid` output 1: block available.
- `o_ready` input 1: downstream accepts block.
- `o_block` output 16*WORD_BITS: message words M0..M15. Word i is at bits [32i+31:32i].
- `o_number` output 32: binary value of the counter encoded in `o_block`.
- `o_exhausted` output 1: sticky; the counter passed 10^NUM_DIGITS−1.
- `o_key_overflow` output 1: sticky; more than MAX_KEY_BYTES key bytes were offered.

## Operation
- States: LOAD → RUN → DONE. Reset enters LOAD with key length 0, counter = 1, all sticky flags cleared.
- **LOAD**
  - Each `key_valid` byte is written at index = key length, and key length increments.
  - Bytes beyond MAX_KEY_BYTES are discarded and set `o_key_overflow`.
  - `key_valid && key_last` moves to RUN. The last byte is stored under the same rule.
  - `key_valid` is ignored outside LOAD.
- **RUN: counter**
  - The counter is held as NUM_DIGITS BCD digits plus a digit count (1..NUM_DIGITS).
  - There are no leading zeros: the most significant digit is emitted first.
- **RUN: block layout**
  - Message bytes are placed in order: key bytes, then digit bytes (0x30+d), then 0x80, then zero fill.
  - Byte n goes in word n/4, bits [8(n%4)+7 : 8(n%4)] (little-endian).
  - M14 = message length in bits = 8·(keylen+digits). M15 = 0.
- **RUN: transfer**
  - A transfer occurs on a cycle with `o_valid && o_ready`.
  - On each transfer, the counter increments in BCD with ripple carry.
  - A carry out of the top used digit increments the digit count; the new top digit is 1 and the rest are 0.
  - A carry out of digit NUM_DIGITS sets `o_exhausted` and goes to DONE. The block for 10^NUM_DIGITS−1 is still delivered.
- **halt**: in LOAD or RUN, goes to DONE next cycle. It takes precedence over a same-cycle transfer's counter update, but that transfer itself completes.
- **DONE**: `o_valid` = 0. The block stays idle until `reset`.
- **Reset mid-operation**: all state returns to LOAD. Any in-flight block is dropped; no partial handshake persists.

## Timing
- Reset values: `o_valid` 0, `o_block` 0, `o_number` 0, `o_exhausted` 0, `o_key_overflow` 0.
- `o_block` and `o_number` are registered outputs.
- The first `o_valid` rises on the cycle after the `key_last` acceptance edge (1-cycle latency), carrying number 1.
- Throughput: one block per cycle while `o_ready` is held high. The next block is valid on the cycle after a transfer; there are no bubbles, including across digit-count changes.
- Backpressure: while `o_valid && !o_ready`, `o_block` and `o_number` are held stable and `o_valid` stays high. The only exception is `halt`, which drops `o_valid` the next cycle.
- Sticky flags update one cycle after their cause.

## Configuration
- `MD5_MSG_GEN_NUMBER_TAG_EN`
- **Defined**: a 32-bit binary counter runs in lockstep with the BCD counter. It resets to 1, increments on each transfer, and drives `o_number`, which is aligned with `o_block`.
- **Undefined**: no binary counter is built and `o_number` is tied to 0. The downstream side recovers the answer from the BCD digits in `o_block`.

## Test plan
- **First block**: key "abcdef" (6 bytes, `key_last` on 'f'), `o_ready` = 1.
  - Next cycle: `o_valid` = 1, M0 = 0x64636261, M1 = 0x80316665, M2..M13 = 0, M14 = 0x38, M15 = 0, `o_number` = 1.
- **Digit rollover**: same key, continue to number 10.
  - M1 = 0x30316665, M2 = 0x00000080, M14 = 0x40, `o_number` = 10.
  - Numbers 1..10 arrive on 10 consecutive cycles.
- **Backpressure**: drop `o_ready` for 5 cycles while number 3 is presented.
  - `o_block` and `o_number` = 3 stay stable. After `o_ready` rises, number 3 transfers once, then 4 follows. No skips and no duplicates.
- **Exhaustion and halt**: with NUM_DIGITS = 2, run to 99.
  - 99 transfers, then `o_exhausted` = 1 and `o_valid` = 0 permanently.
  - Separately, `halt` at number 609043 with key "abcdef" (M14 = 0x60): `o_valid` = 0 next cycle.
- **Key overflow and mid-run reset**:
  - With MAX_KEY_BYTES = 4, key "abcdef" gives `o_key_overflow` = 1 and M1 = 0x00008031.
  - `reset` mid-run gives `o_valid` = 0 and a return to LOAD. Reloading "abcdef" restarts at number 1.
